// File: rtl/qed_pkg.sv
// Shared types, RISC-V field positions and the duplicate-register remap function
// used by the SQED instruction-side sequencer.
package qed_pkg;

    typedef enum logic [1:0] {
        ST_ORIG  = 2'd0,
        ST_DUP   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CHECK = 2'd3
    } qed_state_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam int RD_LSB    = 7;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int REG_W     = 5;
    localparam int DUP_BIT   = 4;

    // Move a nonzero register field into the x16-x31 half; x0 stays x0.
    function automatic logic [31:0] qed_remap(input logic [31:0] inst);
        logic [31:0] r;
        logic        rd_en;
        logic        rs1_en;
        logic        rs2_en;
        r      = inst;
        rd_en  = 1'b0;
        rs1_en = 1'b0;
        rs2_en = 1'b0;
        case (inst[6:0])
            OPC_OP:              begin rd_en = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; end
            OPC_OPIMM, OPC_LOAD: begin rd_en = 1'b1; rs1_en = 1'b1; end
            OPC_STORE:           begin rs1_en = 1'b1; rs2_en = 1'b1; end
            OPC_LUI:             rd_en = 1'b1;
            default:             ;
        endcase
        if (rd_en && (inst[RD_LSB +: REG_W] != '0))   r[RD_LSB + DUP_BIT]  = 1'b1;
        if (rs1_en && (inst[RS1_LSB +: REG_W] != '0)) r[RS1_LSB + DUP_BIT] = 1'b1;
        if (rs2_en && (inst[RS2_LSB +: REG_W] != '0)) r[RS2_LSB + DUP_BIT] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/qed_dup_sequencer_if.sv
// Fetch-side handshake bundle: instruction memory in, core fetch port out.
interface qed_dup_sequencer_if;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_is_dup;

    modport master (
        input  imem_valid, imem_rdata, out_ready,
        output imem_ready, out_valid, out_inst, out_is_dup
    );

    modport slave (
        output imem_valid, imem_rdata, out_ready,
        input  imem_ready, out_valid, out_inst, out_is_dup
    );
endinterface

// File: rtl/qed_inst_fifo.sv
// Circular cache of original instructions awaiting replay as duplicates.
module qed_inst_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[head];

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (push) begin
            tail  <= tail + 1'b1;
            count <= count + 1'b1;
        end else if (pop) begin
            head  <= head + 1'b1;
            count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/qed_dup_sequencer.sv
// SQED instruction-side engine: pass originals through, replay remapped duplicates,
// wait for them to retire, then strobe the checker.
//   state    | meaning
//   ST_ORIG  | pass-through of originals, caching each one
//   ST_DUP   | replay cached instructions with remapped registers
//   ST_DRAIN | wait for every issued instruction to retire
//   ST_CHECK | one-cycle wait_till_commit strobe, cache reset
module qed_dup_sequencer
    import qed_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  exec_dup,
    input  logic                  commit,
    qed_dup_sequencer_if.master   bus,
    output logic                  wait_till_commit,
    output logic                  wait_till_commit_reg,
    output logic                  chk_en,
    output logic [AW:0]           num_orig_insts,
    output logic [AW:0]           num_dup_insts
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    qed_state_t    state;
    qed_state_t    state_nxt;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [AW:0]   cnt_after;
    logic [31:0]   head_data;
    logic          xfer;
    logic          push;
    logic          pop;
    logic [AW+1:0] outstanding;
    logic [AW+1:0] outstanding_nxt;

    assign xfer      = bus.out_valid & bus.out_ready;
    assign push      = (state == ST_ORIG) & xfer;
    assign pop       = (state == ST_DUP) & xfer;
    assign cnt_after = count + {{AW{1'b0}}, push};
    assign chk_en    = wait_till_commit_reg;

    qed_inst_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .clear  (state == ST_CHECK),
        .push   (push),
        .pop    (pop),
        .wdata  (bus.imem_rdata),
        .rdata  (head_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_ORIG;
        else         state <= state_nxt;
    end

    // DRAIN looks at the post-commit value so the strobe follows the last retire by one cycle.
    always_comb begin
        outstanding_nxt = outstanding;
        if (xfer && !commit)                             outstanding_nxt = outstanding + 1'b1;
        else if (!xfer && commit && (outstanding != '0)) outstanding_nxt = outstanding - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ORIG:  if ((exec_dup || (cnt_after == FULL_CNT)) && (cnt_after != '0)) state_nxt = ST_DUP;
            ST_DUP:   if (pop && (count == ONE_CNT)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (outstanding_nxt == '0) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_ORIG;
            default:  state_nxt = ST_ORIG;
        endcase
    end

    always_comb begin
        bus.imem_ready   = 1'b0;
        bus.out_valid    = 1'b0;
        bus.out_inst     = '0;
        bus.out_is_dup   = 1'b0;
        wait_till_commit = 1'b0;
        case (state)
            ST_ORIG: begin
                bus.out_valid  = bus.imem_valid & ~full;
                bus.imem_ready = bus.out_ready & ~full;
                bus.out_inst   = bus.imem_rdata;
            end
            ST_DUP: begin
                bus.out_valid  = ~empty;
                bus.out_is_dup = 1'b1;
                bus.out_inst   = qed_remap(head_data);
            end
            ST_CHECK: wait_till_commit = 1'b1;
            default:  ;
        endcase
    end

    // Round counters stay visible while chk_en is high and clear at the end of that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outstanding          <= '0;
            wait_till_commit_reg <= 1'b0;
            num_orig_insts       <= '0;
            num_dup_insts        <= '0;
        end else begin
            outstanding          <= outstanding_nxt;
            wait_till_commit_reg <= wait_till_commit;
            if (chk_en)    num_orig_insts <= {{AW{1'b0}}, push};
            else if (push) num_orig_insts <= num_orig_insts + 1'b1;
            if (chk_en)    num_dup_insts  <= '0;
            else if (pop)  num_dup_insts  <= num_dup_insts + 1'b1;
        end
    end
endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Scoreboard bench for qed_dup_sequencer: directed instruction vectors with
// hand-computed duplicate encodings; a negedge monitor checks every transfer.
module tb_qed_dup_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          exec_dup = 1'b0;
    logic          commit = 1'b0;
    logic          wait_till_commit;
    logic          wait_till_commit_reg;
    logic          chk_en;
    logic [AW:0]   num_orig_insts;
    logic [AW:0]   num_dup_insts;

    qed_dup_sequencer_if bus ();

    qed_dup_sequencer #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .resetn               (resetn),
        .exec_dup             (exec_dup),
        .commit               (commit),
        .bus                  (bus),
        .wait_till_commit     (wait_till_commit),
        .wait_till_commit_reg (wait_till_commit_reg),
        .chk_en               (chk_en),
        .num_orig_insts       (num_orig_insts),
        .num_dup_insts        (num_dup_insts)
    );

    always #5 clk = ~clk;

    // add, addi x0-src, lw, sw, lui, jal (untouched), sub with rd=x0
    logic [31:0] vo [7] = '{32'h002081B3, 32'h00700293, 32'h00812303, 32'h0070A223,
                            32'h123454B7, 32'h000000EF, 32'h40208033};
    logic [31:0] vd [7] = '{32'h012889B3, 32'h00700A93, 32'h00892B03, 32'h0178A223,
                            32'h12345CB7, 32'h000000EF, 32'h41288033};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int to_commit = 0;
    int last_commit_cycle = -10;
    bit commit_en = 1'b1;
    bit extra_commit = 1'b0;
    logic [32:0] exp_q [$];
    logic [32:0] pend_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (commit_en && to_commit > 0) begin
            commit = 1'b1;
            to_commit--;
            last_commit_cycle = cyc;
        end else begin
            commit = extra_commit;
        end
    end

    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            logic [32:0] e;
            to_commit++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_transfer actual=%h required=none", bus.out_inst);
            end else begin
                e = exp_q.pop_front();
                chk("out_inst", bus.out_inst, e[31:0]);
                chk("out_is_dup", {31'd0, bus.out_is_dup}, {31'd0, e[32]});
            end
        end
    end

    task automatic send_orig(input logic [31:0] inst, input logic [31:0] dup, input bit exec);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = inst;
        bus.out_ready  = 1'b1;
        exec_dup       = exec;
        exp_q.push_back({1'b0, inst});
        pend_q.push_back({1'b1, dup});
        tick();
        bus.imem_valid = 1'b0;
        exec_dup       = 1'b0;
    endtask

    task automatic do_round(input int first, input int n, input bit use_exec,
                            input bit stall, input bit late_commit);
        int t;
        if (late_commit) commit_en = 1'b0;
        for (int i = 0; i < n; i++)
            send_orig(vo[(first + i) % 7], vd[(first + i) % 7], use_exec && (i == n - 1));
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        if (n == DEPTH) begin
            bus.imem_valid = 1'b1;
            #1;
            chk("imem_ready_full", {31'd0, bus.imem_ready}, 32'd0);
            chk("is_dup_after_full", {31'd0, bus.out_is_dup}, 32'd1);
            bus.imem_valid = 1'b0;
        end
        if (stall) begin
            bus.out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
                chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_inst", bus.out_inst, vd[first % 7]);
                chk("stall_num_dup", {27'd0, num_dup_insts}, 32'd0);
                tick();
            end
            bus.out_ready = 1'b1;
        end
        if (late_commit) begin
            t = 0;
            while (num_dup_insts != n[AW:0] && t < 100) begin tick(); t++; end
            repeat (5) tick();
            chk("drain_holds", {31'd0, wait_till_commit}, 32'd0);
            commit_en = 1'b1;
        end
        t = 0;
        while (!wait_till_commit && t < 200) begin tick(); t++; end
        if (t == 200) begin
            total++;
            bad++;
            $display("FAIL wtc_timeout actual=none required=pulse");
        end else begin
            chk("wtc_latency", cyc, last_commit_cycle + 1);
            chk("wtc_num_orig", {27'd0, num_orig_insts}, n);
            chk("wtc_num_dup", {27'd0, num_dup_insts}, n);
            tick();
            chk("wtc_pulse", {31'd0, wait_till_commit}, 32'd0);
            chk("wtc_reg", {31'd0, wait_till_commit_reg}, 32'd1);
            chk("chk_en", {31'd0, chk_en}, 32'd1);
            chk("chk_num_orig", {27'd0, num_orig_insts}, n);
            chk("chk_num_dup", {27'd0, num_dup_insts}, n);
            tick();
            chk("chk_en_off", {31'd0, chk_en}, 32'd0);
            chk("cleared_orig", {27'd0, num_orig_insts}, 32'd0);
            chk("cleared_dup", {27'd0, num_dup_insts}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_imem_ready", {31'd0, bus.imem_ready}, 32'd0);
        chk("rst_is_dup", {31'd0, bus.out_is_dup}, 32'd0);
        chk("rst_wtc", {31'd0, wait_till_commit}, 32'd0);
        chk("rst_wtc_reg", {31'd0, wait_till_commit_reg}, 32'd0);
        chk("rst_chk_en", {31'd0, chk_en}, 32'd0);
        chk("rst_num_orig", {27'd0, num_orig_insts}, 32'd0);
        chk("rst_num_dup", {27'd0, num_dup_insts}, 32'd0);
        resetn = 1'b1;
        tick();

        // exec_dup and a stray commit with nothing cached or outstanding
        exec_dup = 1'b1;
        bus.out_ready = 1'b1;
        extra_commit = 1'b1;
        tick();
        exec_dup = 1'b0;
        extra_commit = 1'b0;
        tick();
        chk("empty_exec_is_dup", {31'd0, bus.out_is_dup}, 32'd0);
        chk("empty_exec_ready", {31'd0, bus.imem_ready}, 32'd1);

        do_round(0, 1, 1'b1, 1'b0, 1'b0);
        do_round(1, 1, 1'b1, 1'b0, 1'b0);
        do_round(2, 5, 1'b1, 1'b1, 1'b0);
        do_round(0, DEPTH, 1'b0, 1'b0, 1'b0);
        do_round(3, 2, 1'b1, 1'b0, 1'b1);
        do_round(4, DEPTH, 1'b0, 1'b0, 1'b0);

        // reset with 4 duplicates still cached
        for (int i = 0; i < 5; i++) send_orig(vo[i], vd[i], i == 4);
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        bus.out_ready = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        #2;
        commit_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_is_dup", {31'd0, bus.out_is_dup}, 32'd0);
        chk("midrst_num_orig", {27'd0, num_orig_insts}, 32'd0);
        chk("midrst_num_dup", {27'd0, num_dup_insts}, 32'd0);
        chk("midrst_chk_en", {31'd0, chk_en}, 32'd0);
        exp_q.delete();
        to_commit = 0;
        repeat (2) tick();
        resetn = 1'b1;
        commit_en = 1'b1;
        tick();
        do_round(5, 2, 1'b1, 1'b0, 1'b0);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
